bullet_render_multi: RTL and testbench

// - Draws up to N_SLOTS enemy/player shells into the VGA pixel stream, replacing the single-shell overlay stage.
// - Per-slot FSM with frame-latched positions (no mid-frame tearing) and a timed explosion sprite on hit.
// - Sits in the draw pipeline between the background/tank stages and the mouse/HUD stage.
// - Timing, rgb and mouse-position buses pass through with a fixed 2-cycle delay.

---
 rtl/bullet_pkg.sv | 38 +++
 rtl/bullet_slot.sv | 142 ++++++++++++++
 rtl/bullet_render_multi.sv | 153 +++++++++++++++
 tb/tb_bullet_render_multi.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
`default_nettype none
// ============================================================================
// Module : bullet_pkg
// Brief  : Shared direction codes, slot state encoding and bound helper for
//          the multi-shell overlay stage.
// Rev    : 1.0  initial release
// ============================================================================
package bullet_pkg;

  localparam logic [2:0] DIR_NONE = 3'd0;
  localparam logic [2:0] DIR_1    = 3'd1;
  localparam logic [2:0] DIR_2    = 3'd2;
  localparam logic [2:0] DIR_3    = 3'd3;
  localparam logic [2:0] DIR_4    = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FLY   = 2'd2;
  localparam logic [1:0] ST_BLAST = 2'd3;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  // Codes 5..7 are treated exactly like DIR_NONE.
  function automatic logic dir_valid(input logic [2:0] d);
    return (d >= DIR_1) && (d <= DIR_4);
  endfunction

  // pos + off in 13-bit signed; a negative result clamps to 0.
  function automatic logic [11:0] edge_at(input logic [9:0] pos,
                                          input logic signed [11:0] off);
    logic signed [12:0] sum;
    sum = $signed({3'b000, pos}) + $signed({off[11], off});
    return sum[12] ? 12'd0 : sum[11:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// ============================================================================
// Module : bullet_slot
// Brief  : One shell slot: FSM, frame-latched shadow position, blast counter
//          and per-pixel hit test.
// Rev    : 1.0  initial release
// ============================================================================
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int BUL_WIDTH    = 2,
  parameter int BUL_LENGTH   = 5,
  parameter int BUL_DIM1     = 19,
  parameter int BUL_DIM2     = 29,
  parameter int BLAST_R      = 6,
  parameter int BLAST_FRAMES = 8
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [9:0]  xpos,
  input  logic [9:0]  ypos,
  input  logic [2:0]  direction,
  input  logic        kill,
  output logic        hit,
  output logic        is_blast
);

  localparam logic signed [11:0] C_W  = 12'(BUL_WIDTH);
  localparam logic signed [11:0] C_L  = 12'(BUL_LENGTH);
  localparam logic signed [11:0] C_D1 = 12'(BUL_DIM1);
  localparam logic signed [11:0] C_D2 = 12'(BUL_DIM2);
  localparam logic signed [11:0] C_R  = 12'(BLAST_R);
  localparam logic [7:0]         C_CNT_INIT = 8'(BLAST_FRAMES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nx;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [2:0]  r_dir;
  logic [7:0]  r_cnt;
  logic        w_dir_ok;
  logic        w_latch;
  logic        w_load_cnt;
  logic        w_dec_cnt;
  logic signed [11:0] w_xl, w_xh, w_yl, w_yh;
  logic [11:0] w_xlo, w_xhi, w_ylo, w_yhi;

  assign w_dir_ok = dir_valid(direction);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // kill has priority over a dropped direction while flying.
  always_comb begin
    w_state_nx = r_state;
    w_latch    = 1'b0;
    w_load_cnt = 1'b0;
    w_dec_cnt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dir_ok) w_state_nx = ST_ARMED;
      end
      ST_ARMED: begin
        if (!w_dir_ok) begin
          w_state_nx = ST_IDLE;
        end else if (fs) begin
          w_state_nx = ST_FLY;
          w_latch    = 1'b1;
        end
      end
      ST_FLY: begin
        if (kill) begin
          w_state_nx = ST_BLAST;
          w_load_cnt = 1'b1;
        end else if (!w_dir_ok) begin
          w_state_nx = ST_IDLE;
        end else if (fs) begin
          w_latch = 1'b1;
        end
      end
      ST_BLAST: begin
        if (fs) begin
          if (r_cnt == 8'd0) w_state_nx = ST_IDLE;
          else               w_dec_cnt  = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_dir <= DIR_NONE;
      r_cnt <= '0;
    end else begin
      if (w_latch) begin
        r_x   <= xpos;
        r_y   <= ypos;
        r_dir <= direction;
      end
      if (w_load_cnt)     r_cnt <= C_CNT_INIT;
      else if (w_dec_cnt) r_cnt <= r_cnt - 8'd1;
    end
  end

  always_comb begin
    w_xl = '0;
    w_xh = '0;
    w_yl = '0;
    w_yh = '0;
    case (r_dir)
      DIR_1: begin w_xl = -C_W;  w_xh = C_W;  w_yl = -C_L; w_yh = C_L;  end
      DIR_2: begin w_xl = -C_W;  w_xh = C_W;  w_yl = C_D1; w_yh = C_D2; end
      DIR_3: begin w_xl = C_D1;  w_xh = C_D2; w_yl = -C_W; w_yh = C_W;  end
      DIR_4: begin w_xl = -C_L;  w_xh = C_L;  w_yl = -C_W; w_yh = C_W;  end
      default: ;
    endcase
    if (r_state == ST_BLAST) begin
      w_xl = -C_R;
      w_xh = C_R;
      w_yl = -C_R;
      w_yh = C_R;
    end
    w_xlo    = edge_at(r_x, w_xl);
    w_xhi    = edge_at(r_x, w_xh);
    w_ylo    = edge_at(r_y, w_yl);
    w_yhi    = edge_at(r_y, w_yh);
    is_blast = (r_state == ST_BLAST);
    hit      = ((r_state == ST_FLY) || is_blast)
               && ({1'b0, hcount}  >= w_xlo) && ({1'b0, hcount}  <= w_xhi)
               && ({2'b00, vcount} >= w_ylo) && ({2'b00, vcount} <= w_yhi);
  end

endmodule
`default_nettype wire

// File: rtl/bullet_render_multi.sv
`default_nettype none
// ============================================================================
// Module : bullet_render_multi
// Brief  : Overlays up to N_SLOTS shells / explosions onto the pixel stream
//          with a fixed two-clock delay on every bus.
// Rev    : 1.0  initial release
// ============================================================================
module bullet_render_multi
  import bullet_pkg::*;
#(
  parameter int          N_SLOTS      = 4,
  parameter int          BUL_WIDTH    = 2,
  parameter int          BUL_LENGTH   = 5,
  parameter int          BUL_DIM1     = 19,
  parameter int          BUL_DIM2     = 29,
  parameter int          BLAST_R      = 6,
  parameter int          BLAST_FRAMES = 8,
  parameter logic [11:0] SHELL_COLOR  = 12'h000,
  parameter logic [11:0] BLAST_COLOR  = 12'hF80
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [10:0]            hcount,
  input  logic [9:0]             vcount,
  input  logic                   hblnk,
  input  logic                   vblnk,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [11:0]            rgb,
  input  logic [11:0]            xpos_mouse_in,
  input  logic [11:0]            ypos_mouse_in,
  input  logic [10*N_SLOTS-1:0]  xpos_bullet,
  input  logic [10*N_SLOTS-1:0]  ypos_bullet,
  input  logic [3*N_SLOTS-1:0]   direction,
  input  logic [N_SLOTS-1:0]     kill,
  output logic [10:0]            hcount_out,
  output logic [9:0]             vcount_out,
  output logic                   hblnk_out,
  output logic                   vblnk_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic [11:0]            rgb_out,
  output logic [11:0]            xpos_mouse_out,
  output logic [11:0]            ypos_mouse_out,
  output logic [N_SLOTS-1:0]     blast_active
);

  logic               r_vblnk_d;
  logic               w_fs;
  logic [N_SLOTS-1:0] w_hit;
  logic [N_SLOTS-1:0] w_blast;

  logic [10:0]        r1_hcount;
  logic [9:0]         r1_vcount;
  logic               r1_hblnk, r1_vblnk, r1_hsync, r1_vsync;
  logic [11:0]        r1_rgb, r1_xm, r1_ym;
  logic [N_SLOTS-1:0] r1_hit;
  logic [N_SLOTS-1:0] r1_blast;
  logic [11:0]        w_pix;

  assign w_fs = vblnk & ~r_vblnk_d;

  generate
    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      bullet_slot #(
        .BUL_WIDTH    (BUL_WIDTH),
        .BUL_LENGTH   (BUL_LENGTH),
        .BUL_DIM1     (BUL_DIM1),
        .BUL_DIM2     (BUL_DIM2),
        .BLAST_R      (BLAST_R),
        .BLAST_FRAMES (BLAST_FRAMES)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .fs        (w_fs),
        .hcount    (hcount),
        .vcount    (vcount),
        .xpos      (xpos_bullet[10*gi +: 10]),
        .ypos      (ypos_bullet[10*gi +: 10]),
        .direction (direction[3*gi +: 3]),
        .kill      (kill[gi]),
        .hit       (w_hit[gi]),
        .is_blast  (w_blast[gi])
      );
    end
  endgenerate

  assign blast_active = w_blast;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d <= 1'b0;
      r1_hcount <= '0;
      r1_vcount <= '0;
      r1_hblnk  <= 1'b0;
      r1_vblnk  <= 1'b0;
      r1_hsync  <= 1'b0;
      r1_vsync  <= 1'b0;
      r1_rgb    <= '0;
      r1_xm     <= '0;
      r1_ym     <= '0;
      r1_hit    <= '0;
      r1_blast  <= '0;
    end else begin
      r_vblnk_d <= vblnk;
      r1_hcount <= hcount;
      r1_vcount <= vcount;
      r1_hblnk  <= hblnk;
      r1_vblnk  <= vblnk;
      r1_hsync  <= hsync;
      r1_vsync  <= vsync;
      r1_rgb    <= rgb;
      r1_xm     <= xpos_mouse_in;
      r1_ym     <= ypos_mouse_in;
      r1_hit    <= w_hit;
      r1_blast  <= w_blast;
    end
  end

  // Walk from the top slot down so the lowest-index hit is applied last.
  always_comb begin
    w_pix = r1_rgb;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (r1_hit[i]) w_pix = r1_blast[i] ? BLAST_COLOR : SHELL_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out     <= '0;
      vcount_out     <= '0;
      hblnk_out      <= 1'b0;
      vblnk_out      <= 1'b0;
      hsync_out      <= 1'b0;
      vsync_out      <= 1'b0;
      rgb_out        <= '0;
      xpos_mouse_out <= '0;
      ypos_mouse_out <= '0;
    end else begin
      hcount_out     <= r1_hcount;
      vcount_out     <= r1_vcount;
      hblnk_out      <= r1_hblnk;
      vblnk_out      <= r1_vblnk;
      hsync_out      <= r1_hsync;
      vsync_out      <= r1_vsync;
      rgb_out        <= w_pix;
      xpos_mouse_out <= r1_xm;
      ypos_mouse_out <= r1_ym;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bullet_render_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_bullet_render_multi
// Brief  : Directed tables, corner sequences and random frames against a
//          behavioural model of the shell overlay.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bullet_render_multi;
  import bullet_pkg::SCREEN_W;
  import bullet_pkg::SCREEN_H;

  localparam int N = 4;
  localparam int BW = 2, BL = 5, D1 = 19, D2 = 29, BR = 6, BF = 8;
  localparam logic [11:0] SHELL = 12'h000;
  localparam logic [11:0] BLAST = 12'hF80;
  localparam logic [11:0] BG    = 12'h5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic          hblnk, vblnk, hsync, vsync;
  logic [11:0]   rgb, xm_in, ym_in;
  logic [10*N-1:0] xpos_bullet, ypos_bullet;
  logic [3*N-1:0]  direction;
  logic [N-1:0]    kill;
  logic [10:0]   hcount_out;
  logic [9:0]    vcount_out;
  logic          hblnk_out, vblnk_out, hsync_out, vsync_out;
  logic [11:0]   rgb_out, xm_out, ym_out;
  logic [N-1:0]  blast_active;
  logic [48:0]   tim_out;

  bullet_render_multi dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .xpos_mouse_in(xm_in), .ypos_mouse_in(ym_in),
    .xpos_bullet(xpos_bullet), .ypos_bullet(ypos_bullet),
    .direction(direction), .kill(kill),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb_out(rgb_out),
    .xpos_mouse_out(xm_out), .ypos_mouse_out(ym_out),
    .blast_active(blast_active)
  );

  assign tim_out = {hcount_out, vcount_out, hblnk_out, vblnk_out,
                    hsync_out, vsync_out, xm_out, ym_out};

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_ARMED, M_FLY, M_BLAST} mstate_e;
  mstate_e m_st[N];
  int      m_x[N], m_y[N], m_d[N], m_left[N];
  bit      m_pv;

  typedef struct {
    logic [11:0] rgb;
    logic [48:0] tim;
    bit          has_tab;
    logic [11:0] tab;
  } ent_t;
  ent_t q[$];

  typedef struct {
    int          h;
    int          v;
    logic [11:0] exp;
  } vec_t;

  int total = 0;
  int bad = 0;
  bit          g_has_tab = 0;
  logic [11:0] g_tab = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_box(int i, int h, int v);
    int x0, x1, y0, y1;
    if (m_st[i] == M_BLAST) begin
      x0 = m_x[i] - BR; x1 = m_x[i] + BR; y0 = m_y[i] - BR; y1 = m_y[i] + BR;
    end else begin
      case (m_d[i])
        1:       begin x0 = m_x[i]-BW; x1 = m_x[i]+BW; y0 = m_y[i]-BL; y1 = m_y[i]+BL; end
        2:       begin x0 = m_x[i]-BW; x1 = m_x[i]+BW; y0 = m_y[i]+D1; y1 = m_y[i]+D2; end
        3:       begin x0 = m_x[i]+D1; x1 = m_x[i]+D2; y0 = m_y[i]-BW; y1 = m_y[i]+BW; end
        default: begin x0 = m_x[i]-BL; x1 = m_x[i]+BL; y0 = m_y[i]-BW; y1 = m_y[i]+BW; end
      endcase
    end
    if (x0 < 0) x0 = 0;
    if (y0 < 0) y0 = 0;
    return (h >= x0) && (h <= x1) && (v >= y0) && (v <= y1);
  endfunction

  function automatic logic [11:0] model_pixel(int h, int v, logic [11:0] up);
    for (int i = 0; i < N; i++) begin
      if ((m_st[i] == M_FLY || m_st[i] == M_BLAST) && in_box(i, h, v))
        return (m_st[i] == M_BLAST) ? BLAST : SHELL;
    end
    return up;
  endfunction

  function automatic logic [N-1:0] model_blast();
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = (m_st[i] == M_BLAST);
    return b;
  endfunction

  task automatic model_step();
    bit fs;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = M_IDLE; m_x[i] = 0; m_y[i] = 0; m_d[i] = 0; m_left[i] = 0;
      end
      m_pv = 0;
      return;
    end
    fs   = vblnk && !m_pv;
    m_pv = vblnk;
    for (int i = 0; i < N; i++) begin
      int d;
      bit live;
      d    = int'(direction[3*i +: 3]);
      live = (d >= 1) && (d <= 4);
      case (m_st[i])
        M_IDLE:  if (live) m_st[i] = M_ARMED;
        M_ARMED: if (!live) m_st[i] = M_IDLE;
                 else if (fs) begin
                   m_st[i] = M_FLY; m_d[i] = d;
                   m_x[i] = int'(xpos_bullet[10*i +: 10]); m_y[i] = int'(ypos_bullet[10*i +: 10]);
                 end
        M_FLY:   if (kill[i]) begin m_st[i] = M_BLAST; m_left[i] = BF - 1; end
                 else if (!live) m_st[i] = M_IDLE;
                 else if (fs) begin
                   m_d[i] = d;
                   m_x[i] = int'(xpos_bullet[10*i +: 10]); m_y[i] = int'(ypos_bullet[10*i +: 10]);
                 end
        default: if (fs) begin
                   if (m_left[i] == 0) m_st[i] = M_IDLE;
                   else m_left[i]--;
                 end
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge with inputs already driven.
  task automatic cyc();
    ent_t e;
    if (rst) begin
      e.rgb = '0; e.tim = '0; e.has_tab = 0; e.tab = '0;
    end else begin
      e.rgb     = model_pixel(int'(hcount), int'(vcount), rgb);
      e.tim     = {hcount, vcount, hblnk, vblnk, hsync, vsync, xm_in, ym_in};
      e.has_tab = g_has_tab;
      e.tab     = g_tab;
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      chk("reset_rgb", 64'(rgb_out), 64'd0);
      chk("reset_timing", 64'(tim_out), 64'd0);
      q.delete();
      q.push_back(e);
    end else begin
      q.push_back(e);
      if (q.size() >= 2) begin
        ent_t o;
        o = q.pop_front();
        chk("rgb_out", 64'(rgb_out), 64'(o.rgb));
        chk("timing", 64'(tim_out), 64'(o.tim));
        if (o.has_tab) chk("vector_rgb", 64'(rgb_out), 64'(o.tab));
      end
    end
    chk("blast_active", 64'(blast_active), 64'(model_blast()));
  endtask

  task automatic rand_side();
    hsync = 1'($urandom); vsync = 1'($urandom);
    xm_in = 12'($urandom); ym_in = 12'($urandom);
  endtask

  task automatic pix(input int h, input int v);
    hcount = 11'(h); vcount = 10'(v); hblnk = 1'b0; vblnk = 1'b0;
    rgb = 12'($urandom); rand_side();
    cyc();
  endtask

  task automatic pix_exp(input int h, input int v, input logic [11:0] exp);
    hcount = 11'(h); vcount = 10'(v); hblnk = 1'b0; vblnk = 1'b0;
    rgb = BG; rand_side();
    g_has_tab = 1; g_tab = exp;
    cyc();
    g_has_tab = 0;
  endtask

  task automatic frame();
    for (int k = 0; k < 3; k++) begin
      hcount = 11'd1500; vcount = 10'd900; hblnk = 1'b1; vblnk = 1'b1;
      rgb = 12'($urandom); rand_side();
      cyc();
    end
    vblnk = 1'b0; hblnk = 1'b0;
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int d);
    xpos_bullet[10*i +: 10] = 10'(x);
    ypos_bullet[10*i +: 10] = 10'(y);
    direction[3*i +: 3]     = 3'(d);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t tv[12];
    tv[0]  = '{97,  200, BG};    tv[1]  = '{98,  200, SHELL};
    tv[2]  = '{102, 200, SHELL}; tv[3]  = '{103, 200, BG};
    tv[4]  = '{100, 194, BG};    tv[5]  = '{100, 195, SHELL};
    tv[6]  = '{100, 205, SHELL}; tv[7]  = '{100, 206, BG};
    tv[8]  = '{98,  195, SHELL}; tv[9]  = '{102, 205, SHELL};
    tv[10] = '{103, 205, BG};    tv[11] = '{0,   0,   BG};

    // Reset with random inputs on every bus.
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      hcount = 11'($urandom); vcount = 10'($urandom);
      hblnk = 1'($urandom); vblnk = 1'($urandom); rgb = 12'($urandom); rand_side();
      xpos_bullet = 40'({$urandom, $urandom}); ypos_bullet = 40'({$urandom, $urandom});
      direction = 12'($urandom); kill = 4'($urandom);
      cyc();
    end
    chk("reset_blast_active", 64'(blast_active), 64'd0);
    rst = 1'b0;
    xpos_bullet = '0; ypos_bullet = '0; direction = '0; kill = '0;
    pix(0, 0); pix(0, 0);
    frame();

    // Single shell, drawn from the next frame.
    set_slot(0, 100, 200, 1);
    pix_exp(100, 200, BG);
    pix_exp(100, 200, BG);
    frame();
    for (int k = 0; k < 12; k++) pix_exp(tv[k].h, tv[k].v, tv[k].exp);

    // Mid-frame move only takes effect at the next frame.
    set_slot(0, 300, 200, 1);
    pix_exp(100, 200, SHELL);
    pix_exp(300, 200, BG);
    frame();
    pix_exp(298, 200, SHELL); pix_exp(302, 200, SHELL);
    pix_exp(297, 200, BG);    pix_exp(100, 200, BG);
    set_slot(0, 0, 0, 0);
    pix(0, 700);

    // Blast near the top edge, vertical bound clamped.
    set_slot(1, 50, 3, 1);
    pix(0, 700);
    frame();
    pix_exp(50, 0, SHELL);
    kill[1] = 1'b1; pix(0, 700); kill[1] = 1'b0;
    set_slot(1, 500, 500, 0);
    for (int f = 0; f < BF; f++) begin
      chk("blast_frame_active", 64'(blast_active[1]), 64'd1);
      pix_exp(44, 0, BLAST); pix_exp(56, 9, BLAST);
      pix_exp(43, 0, BG);    pix_exp(57, 5, BG); pix_exp(50, 10, BG);
      frame();
    end
    chk("blast_expired", 64'(blast_active[1]), 64'd0);
    pix_exp(50, 3, BG);

    // Overlap: shell on slot0 beats blast on slot2.
    set_slot(0, 400, 400, 1);
    set_slot(2, 400, 400, 1);
    pix(0, 700);
    frame();
    kill[2] = 1'b1; pix(0, 700); kill[2] = 1'b0;
    pix_exp(400, 400, SHELL); pix_exp(404, 400, BLAST);
    set_slot(0, 400, 400, 0);
    pix(0, 700);
    pix_exp(400, 400, BLAST);

    // kill and direction drop in the same cycle while flying.
    set_slot(3, 600, 300, 4);
    pix(0, 700);
    frame();
    pix_exp(600, 300, SHELL);
    direction[3*3 +: 3] = 3'd0; kill[3] = 1'b1;
    pix(0, 700);
    kill[3] = 1'b0;
    chk("kill_beats_dir0", 64'(blast_active[3]), 64'd1);
    pix_exp(600, 300, BLAST); pix_exp(606, 306, BLAST); pix_exp(607, 300, BG);

    // Invalid direction code leaves the slot idle.
    set_slot(0, 700, 500, 6);
    pix(0, 700);
    frame();
    pix_exp(700, 500, BG); pix_exp(702, 505, BG);
    set_slot(0, 0, 0, 0);

    // Random frames against the model, with one mid-frame reset.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) direction[3*i +: 3] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) begin
          xpos_bullet[10*i +: 10] = 10'($urandom_range(0, SCREEN_W - 1));
          ypos_bullet[10*i +: 10] = 10'($urandom_range(0, SCREEN_H - 1));
        end
      end
      frame();
      for (int p = 0; p < 60; p++) begin
        int i, h, v;
        for (int j = 0; j < N; j++) kill[j] = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 49) == 0) begin
          i = int'($urandom_range(0, N - 1));
          xpos_bullet[10*i +: 10] = 10'($urandom_range(0, SCREEN_W - 1));
          direction[3*i +: 3] = 3'($urandom_range(0, 7));
        end
        if (f == 20 && p == 30) rst = 1'b1;
        if (f == 20 && p == 32) rst = 1'b0;
        i = int'($urandom_range(0, N - 1));
        h = int'(xpos_bullet[10*i +: 10]) + int'($urandom_range(0, 70)) - 35;
        v = int'(ypos_bullet[10*i +: 10]) + int'($urandom_range(0, 70)) - 35;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        pix(h, v);
      end
      kill = '0;
    end
    pix(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
